div_dispatch: RTL and testbench
===============================

# div_dispatch

Operand queue and issue sequencer placed directly upstream of the iterative divider `div_fsm`. It accepts divide requests on a valid/ready port and buffers them in a small FIFO. It issues requests to the divider one at a time through the divider's `en`/`ready`/`vld_out` handshake and returns results in request order on a valid/ready response port. Divide-by-zero is resolved locally, without using the divider.

## Interface
- `DATAWIDTH`, 16, operand/result width; must match the divider.
- `DEPTH`, 4, request FIFO entries; power of two, ≥2.

- `clk` in 1: single clock, all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_vld` in 1: request valid.
- `req_rdy` out 1: request ready; equals FIFO not full.
- `req_dividend` in DATAWIDTH: dividend.
- `req_divisor` in DATAWIDTH: divisor.
- `div_en` out 1: issue strobe to the divider `en`.
- `div_ready` in 1: divider `ready`.
- `div_dividend` out DATAWIDTH: FIFO head dividend.
- `div_divisor` out DATAWIDTH: FIFO head divisor.
- `div_quotient` in DATAWIDTH: divider quotient.
- `div_remainder` in DATAWIDTH: divider remainder.
- `div_vld` in 1: divider `vld_out`.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: response ready.
- `rsp_quotient` out DATAWIDTH: registered quotient.
- `rsp_remainder` out DATAWIDTH: registered remainder.
- `rsp_dz` out 1: response came from a zero divisor.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.

## Operation
- **Push:** at an edge where `req_vld && req_rdy`. There is no bypass; a full FIFO refuses input even if a pop happens in the same cycle.
- **Push and pop together:** both take effect in the same cycle; the count is unchanged. Pointers wrap modulo DEPTH.
- **Divider handshake:** the divider takes operands at an edge where `div_en && div_ready`. It later pulses `div_vld` for exactly one cycle, with the result valid in that cycle.
- **FSM state IDLE:**
  - FIFO empty: stay in IDLE.
  - Head divisor == 0: load the response register with quotient = all ones, remainder = head dividend, dz = 1. Pop the head and go to HOLD.
  - Otherwise: go to ISSUE.
- **FSM state ISSUE:**
  - `div_en` = 1, with `div_dividend`/`div_divisor` taken from the head.
  - On an edge with `div_ready` = 1: pop the head and go to WAIT.
- **FSM state WAIT:**
  - `div_en` = 0.
  - On an edge with `div_vld` = 1: capture `div_quotient`/`div_remainder`, set dz = 0, go to HOLD.
- **FSM state HOLD:**
  - `rsp_vld` = 1.
  - On an edge with `rsp_rdy` = 1: go to IDLE.
- **Stray `div_vld`:** ignored in every state except WAIT.
- **In flight:** at most one request is inside the divider; responses are strictly in request order.
- **Arithmetic:** none beyond the zero compare on the divisor. Quotient and remainder pass through unmodified.

## Timing
- **Reset values (rstn low):**
  - State = IDLE; FIFO empty; pointers = 0.
  - FIFO storage and the response register = 0.
  - Outputs: `req_rdy` = 1; `div_en`, `rsp_vld`, `rsp_dz`, `busy` = 0; all data outputs = 0.
- **Reset mid-operation:** all pending and in-flight requests are dropped, and no response is produced for them. A `div_vld` pulse arriving after reset is ignored.
- **Non-zero divisor, divider idle:** push at edge N. `div_en` is high after edge N+1. Pop at edge N+2. Capture at the `div_vld` edge, and `rsp_vld` is high from the following cycle.
- **Zero divisor:** push at edge N; `rsp_vld` is high after edge N+1.
- **Bubble:** HOLD→IDLE costs one idle cycle before the next issue.
- **Stable responses:** `rsp_*` outputs stay stable while `rsp_vld && !rsp_rdy`.
- **Stall in ISSUE:** while `div_ready` is low, `div_en` stays high and the head operands stay stable.

## Test plan
- **Single divide:** 100/7 through a real `div_fsm`. Expect `rsp_quotient` = 14, `rsp_remainder` = 2, `rsp_dz` = 0, and exactly one `div_en`/`div_ready` handshake.
- **Divide by zero:** 50/0. Expect `rsp_quotient` = 0xFFFF, `rsp_remainder` = 50, `rsp_dz` = 1, `rsp_vld` two edges after the push, and `div_en` never asserted.
- **Overflow and ordering:** hold `div_ready` low and push 5 requests (900/30, 17/5, 8/0, 999/99, 3/4).
  - `req_rdy` drops after 4 pushes.
  - After `div_ready` is released, responses arrive in order: (30,0), (3,2), (0xFFFF,8,dz), (10,9), (0,3).
- **Response backpressure:** hold `rsp_rdy` low for 10 cycles with a result pending. The response stays stable, the next request is not issued, and it is released one cycle after `rsp_rdy` goes high.
- **Reset in WAIT:** assert `rstn` low in WAIT, then inject a stray `div_vld`. All outputs return to reset values, `rsp_vld` stays 0, and `busy` = 0.
- **Concurrent push and pop:** push and pop in the same cycle with 2 entries queued. Occupancy stays at 2; run 20 random operands against the `/` and `%` models with divisor range 0–99.

Source files
------------

// File: rtl/div_dispatch.sv
// Request FIFO and one-at-a-time issue sequencer in front of an iterative divider.
// Zero divisors are answered locally; responses leave in request order.
module div_dispatch #(
   parameter int DATAWIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req_vld,
   output logic                 req_rdy,
   input  logic [DATAWIDTH-1:0] req_dividend,
   input  logic [DATAWIDTH-1:0] req_divisor,
   output logic                 div_en,
   input  logic                 div_ready,
   output logic [DATAWIDTH-1:0] div_dividend,
   output logic [DATAWIDTH-1:0] div_divisor,
   input  logic [DATAWIDTH-1:0] div_quotient,
   input  logic [DATAWIDTH-1:0] div_remainder,
   input  logic                 div_vld,
   output logic                 rsp_vld,
   input  logic                 rsp_rdy,
   output logic [DATAWIDTH-1:0] rsp_quotient,
   output logic [DATAWIDTH-1:0] rsp_remainder,
   output logic                 rsp_dz,
   output logic                 busy
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t               state;
   logic [DATAWIDTH-1:0] mem_dividend [DEPTH];
   logic [DATAWIDTH-1:0] mem_divisor  [DEPTH];
   logic [AW-1:0]        wptr;
   logic [AW-1:0]        rptr;
   logic [AW:0]          count;
   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 head_zero;

   assign empty        = (count == '0);
   assign full         = (count == (AW+1)'(DEPTH));
   assign req_rdy      = !full;
   assign push         = req_vld && !full;
   assign div_dividend = mem_dividend[rptr];
   assign div_divisor  = mem_divisor[rptr];
   assign head_zero    = (mem_divisor[rptr] == '0);
   assign busy         = !empty || (state != IDLE);

   // A zero-divisor head leaves the FIFO straight from IDLE; others leave on the issue handshake.
   assign pop = ((state == IDLE) && !empty && head_zero) ||
                ((state == ISSUE) && div_ready);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_dividend[i] <= '0;
            mem_divisor[i]  <= '0;
         end
      end else begin
         if (push) begin
            mem_dividend[wptr] <= req_dividend;
            mem_divisor[wptr]  <= req_divisor;
            wptr               <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         div_en        <= 1'b0;
         rsp_vld       <= 1'b0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_dz        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (head_zero) begin
                     rsp_quotient  <= '1;
                     rsp_remainder <= mem_dividend[rptr];
                     rsp_dz        <= 1'b1;
                     rsp_vld       <= 1'b1;
                     state         <= HOLD;
                  end else begin
                     div_en <= 1'b1;
                     state  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (div_ready) begin
                  div_en <= 1'b0;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               // div_vld outside this state is a stray pulse and must not touch the response.
               if (div_vld) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_dz        <= 1'b0;
                  rsp_vld       <= 1'b1;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (rsp_rdy) begin
                  rsp_vld <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               div_en  <= 1'b0;
               rsp_vld <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_dispatch.sv
// Bench for div_dispatch: behavioural iterative divider plus an in-order response scoreboard.
module tb_div_dispatch;

   localparam int DW     = 16;
   localparam int DV_LAT = 6;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_vld = 1'b0;
   logic          req_rdy;
   logic [DW-1:0] req_dividend = '0;
   logic [DW-1:0] req_divisor = '0;
   logic          div_en;
   logic          div_ready;
   logic [DW-1:0] div_dividend;
   logic [DW-1:0] div_divisor;
   logic [DW-1:0] div_quotient;
   logic [DW-1:0] div_remainder;
   logic          div_vld = 1'b0;
   logic          rsp_vld;
   logic          rsp_rdy = 1'b1;
   logic [DW-1:0] rsp_quotient;
   logic [DW-1:0] rsp_remainder;
   logic          rsp_dz;
   logic          busy;

   div_dispatch #(.DATAWIDTH(DW), .DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .req_vld(req_vld), .req_rdy(req_rdy),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .div_en(div_en), .div_ready(div_ready),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_vld(div_vld),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural divider: takes operands on en&&ready, pulses vld DV_LAT cycles later.
   logic          stall_ready = 1'b0;
   logic          dv_busy = 1'b0;
   int            dv_cnt = 0;
   logic [DW-1:0] dv_q = '0;
   logic [DW-1:0] dv_r = '0;
   int            hs_cnt = 0;
   int            en_cnt = 0;

   assign div_ready     = !dv_busy && !stall_ready;
   assign div_quotient  = dv_q;
   assign div_remainder = dv_r;

   always @(posedge clk) begin
      div_vld <= 1'b0;
      if (div_en) en_cnt <= en_cnt + 1;
      if (dv_busy) begin
         if (dv_cnt == 0) begin
            div_vld <= 1'b1;
            dv_busy <= 1'b0;
         end else begin
            dv_cnt <= dv_cnt - 1;
         end
      end else if (div_en && div_ready) begin
         hs_cnt  <= hs_cnt + 1;
         dv_busy <= 1'b1;
         dv_cnt  <= DV_LAT - 1;
         dv_q    <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
         dv_r    <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      end
   end

   typedef struct packed {
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          dz;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Monitor: every accepted response is compared against the oldest expectation.
   always @(negedge clk) begin
      rsp_t e;
      if (rstn && rsp_vld && rsp_rdy) begin
         if (exp_q.size() == 0) begin
            timeout("rsp_unexpected");
         end else begin
            e = exp_q.pop_front();
            check("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
            check("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
            check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
         end
      end
   end

   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic edz);
      int n;
      rsp_t e;
      @(posedge clk); #1;
      req_vld = 1'b1; req_dividend = a; req_divisor = b;
      n = 0;
      @(negedge clk);
      while (!req_rdy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!req_rdy) timeout("push_wait");
      e.q = eq; e.r = er; e.dz = edz;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_vld = 1'b0;
   endtask

   task automatic push_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (b == 0) push(a, b, '1, a, 1'b1);
      else        push(a, b, a / b, a % b, 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy || exp_q.size() != 0) timeout("wait_idle");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      int en0;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_rdy", 32'(req_rdy), 32'd1);
      check("rst_div_en", 32'(div_en), 32'd0);
      check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      check("rst_rsp_dz", 32'(rsp_dz), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_q", 32'(rsp_quotient), 32'd0);
      check("rst_div_dividend", 32'(div_dividend), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;

      // Single divide 100/7
      hs0 = hs_cnt;
      push(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      @(negedge clk);
      check("single_en_n", 32'(div_en), 32'd0);
      @(negedge clk);
      check("single_en_n1", 32'(div_en), 32'd1);
      wait_idle();
      check("single_handshakes", 32'(hs_cnt - hs0), 32'd1);

      // Divide by zero 50/0
      en0 = en_cnt;
      push(16'd50, 16'd0, 16'hFFFF, 16'd50, 1'b1);
      @(negedge clk);
      check("dz_vld_n", 32'(rsp_vld), 32'd0);
      @(negedge clk);
      check("dz_vld_n1", 32'(rsp_vld), 32'd1);
      wait_idle();
      check("dz_no_en", 32'(en_cnt - en0), 32'd0);

      // Overflow and ordering with the divider stalled
      stall_ready = 1'b1;
      push(16'd900, 16'd30, 16'd30, 16'd0, 1'b0);
      push(16'd17, 16'd5, 16'd3, 16'd2, 1'b0);
      push(16'd8, 16'd0, 16'hFFFF, 16'd8, 1'b1);
      push(16'd999, 16'd99, 16'd10, 16'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ovf_full", 32'(req_rdy), 32'd0);
         check("ovf_stall_en", 32'(div_en), 32'd1);
         check("ovf_stall_a", 32'(div_dividend), 32'd900);
         check("ovf_stall_b", 32'(div_divisor), 32'd30);
      end
      @(posedge clk); #1;
      stall_ready = 1'b0;
      push(16'd3, 16'd4, 16'd0, 16'd3, 1'b0);
      wait_idle();

      // Response backpressure
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      push(16'd40, 16'd6, 16'd6, 16'd4, 1'b0);
      push(16'd41, 16'd7, 16'd5, 16'd6, 1'b0);
      n = 0;
      @(negedge clk);
      while (!rsp_vld && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_vld) timeout("bp_wait_vld");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_vld", 32'(rsp_vld), 32'd1);
         check("bp_q", 32'(rsp_quotient), 32'd6);
         check("bp_r", 32'(rsp_remainder), 32'd4);
         check("bp_no_issue", 32'(div_en), 32'd0);
      end
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      @(negedge clk);
      check("bp_rel_e0", 32'(div_en), 32'd0);
      @(negedge clk);
      check("bp_rel_e1", 32'(div_en), 32'd0);
      @(negedge clk);
      check("bp_rel_e2", 32'(div_en), 32'd1);
      wait_idle();

      // Reset while the divider holds a request
      push(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
      n = 0;
      @(negedge clk);
      while (!dv_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!dv_busy) timeout("wait_issue");
      @(posedge clk); #1;
      rstn = 1'b0;
      exp_q.delete();
      #1;
      check("rstw_rsp_vld", 32'(rsp_vld), 32'd0);
      check("rstw_busy", 32'(busy), 32'd0);
      check("rstw_div_en", 32'(div_en), 32'd0);
      check("rstw_req_rdy", 32'(req_rdy), 32'd1);
      check("rstw_rsp_q", 32'(rsp_quotient), 32'd0);
      check("rstw_rsp_r", 32'(rsp_remainder), 32'd0);
      check("rstw_div_dividend", 32'(div_dividend), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < DV_LAT + 4; i++) begin
         @(negedge clk);
         check("rstw_quiet_vld", 32'(rsp_vld), 32'd0);
         check("rstw_quiet_busy", 32'(busy), 32'd0);
      end

      // Concurrent push and pop with two entries queued
      stall_ready = 1'b1;
      push(16'd11, 16'd2, 16'd5, 16'd1, 1'b0);
      push(16'd13, 16'd4, 16'd3, 16'd1, 1'b0);
      @(posedge clk); #1;
      req_vld = 1'b1; req_dividend = 16'd20; req_divisor = 16'd3;
      stall_ready = 1'b0;
      @(negedge clk);
      check("cc_push_rdy", 32'(req_rdy), 32'd1);
      check("cc_pop_en", 32'(div_en && div_ready), 32'd1);
      exp_q.push_back(rsp_t'{q: 16'd6, r: 16'd2, dz: 1'b0});
      @(posedge clk); #1;
      req_vld = 1'b0;
      stall_ready = 1'b1;
      push(16'd7, 16'd7, 16'd1, 16'd0, 1'b0);
      @(negedge clk);
      check("cc_occ3_rdy", 32'(req_rdy), 32'd1);
      push(16'd9, 16'd0, 16'hFFFF, 16'd9, 1'b1);
      @(negedge clk);
      check("cc_occ4_full", 32'(req_rdy), 32'd0);
      @(posedge clk); #1;
      stall_ready = 1'b0;
      wait_idle();

      // Random operands, divisor 0..99
      for (int i = 0; i < 20; i++) begin
         push_model(DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 99)));
      end
      wait_idle();
      check("end_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
